// File: rtl/ioctl_replay_tx.sv
// Replays a byte image from a synchronous source memory as an ioctl download
// stream (download window, per-byte write strobes, address and data).
module ioctl_replay_tx #(
  parameter int unsigned AW     = 25,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned GAP    = 4,
  parameter int unsigned PRE    = 8,
  parameter int unsigned POST   = 8
) (
  input  logic          clk_sys,
  input  logic          I_RESETn,
  input  logic          start,
  input  logic          abort,
  input  logic          hold,
  input  logic [7:0]    index_in,
  input  logic [AW-1:0] dst_base,
  input  logic [AW-1:0] length,
  output logic [AW-1:0] src_addr,
  output logic          src_rd,
  input  logic [7:0]    src_data,
  output logic          ioctl_download,
  output logic [7:0]    ioctl_index,
  output logic          ioctl_wr,
  output logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_dout,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_FETCH, S_WAIT, S_WRITE, S_GAP, S_POST, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     offset_q, offset_d, offset_inc;
  logic [AW-1:0]     base_q, len_q;
  logic              accept_c;

  assign offset_inc = offset_q + AW'(1);

  // Next-state logic; abort overrides every non-idle transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          accept_c = 1'b1;
          state_d  = S_PRE;
          cnt_d    = '0;
          offset_d = '0;
        end
      end
      S_PRE: begin
        if (!hold) begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? S_POST : S_FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == RD_LAST) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        offset_d = offset_inc;
        cnt_d    = '0;
        if (offset_inc == len_q) begin
          state_d = S_POST;
        end else if (GAP == 0) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (!hold) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_POST: begin
        if (cnt_q == POST_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      offset_q <= '0;
      base_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      if (accept_c) begin
        base_q <= dst_base;
        len_q  <= length;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      busy           <= 1'b0;
      ioctl_download <= 1'b0;
      src_rd         <= 1'b0;
      ioctl_wr       <= 1'b0;
      done           <= 1'b0;
      src_addr       <= '0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      ioctl_index    <= '0;
    end else begin
      busy           <= (state_d != S_IDLE);
      ioctl_download <= (state_d != S_IDLE) && (state_d != S_DONE);
      src_rd         <= (state_d == S_FETCH);
      ioctl_wr       <= (state_d == S_WRITE);
      done           <= (state_d == S_DONE);
      if (state_d == S_FETCH) begin
        src_addr <= offset_d;
      end
      // Entering WRITE is the last WAIT cycle, when src_data carries the fetched byte.
      if (state_d == S_WRITE) begin
        ioctl_addr <= base_q + offset_q;
        ioctl_dout <= src_data;
      end
      if (accept_c) begin
        ioctl_index <= index_in;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_replay_tx.sv
// Bench for ioctl_replay_tx: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ioctl_replay_tx;

  localparam int unsigned AW     = 25;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned GAP    = 4;
  localparam int unsigned PRE    = 8;
  localparam int unsigned POST   = 8;
  localparam int LOG = 4096;

  logic          clk_sys = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic [7:0]    index_in = '0;
  logic [AW-1:0] dst_base = '0, length = '0;
  logic [AW-1:0] src_addr, ioctl_addr;
  logic          src_rd, ioctl_download, ioctl_wr, busy, done;
  logic [7:0]    src_data, ioctl_index, ioctl_dout;

  always #5 clk_sys = ~clk_sys;

  ioctl_replay_tx #(.AW(AW), .RD_LAT(RD_LAT), .GAP(GAP), .PRE(PRE), .POST(POST)) dut (
    .clk_sys(clk_sys), .I_RESETn(rst_n), .start(start), .abort(abort), .hold(hold),
    .index_in(index_in), .dst_base(dst_base), .length(length),
    .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .busy(busy), .done(done)
  );

  // Source memory: data appears RD_LAT cycles after src_rd, noise at all other times.
  logic [7:0] mem [256];
  logic [7:0] pd [RD_LAT];
  logic       pv [RD_LAT] = '{default: 1'b0};
  logic [7:0] noise = 8'h5A;
  int         cyc = 0;
  assign src_data = pv[RD_LAT-1] ? pd[RD_LAT-1] : noise;

  initial forever begin
    @(posedge clk_sys);
    pd[0] <= mem[src_addr[7:0]];
    pv[0] <= src_rd;
    for (int i = 1; i < RD_LAT; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
    noise <= 8'($urandom);
    cyc   <= cyc + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs for the current cycle.
  logic          exp_busy, exp_dl, exp_wr, exp_rd, exp_done;
  logic [AW-1:0] exp_saddr, exp_addr, m_base, m_len;
  logic [7:0]    exp_dout, exp_index, m_idx;

  task automatic zero_all();
    exp_busy = 0; exp_dl = 0; exp_wr = 0; exp_rd = 0; exp_done = 0;
    exp_saddr = '0; exp_addr = '0; exp_dout = '0; exp_index = '0;
  endtask

  task automatic go_idle();
    if (!rst_n) zero_all();
    else begin
      exp_busy = 0; exp_dl = 0; exp_wr = 0; exp_rd = 0; exp_done = 0;
    end
  endtask

  task automatic tick(output bit brk, output bit h);
    @(posedge clk_sys or negedge rst_n);
    brk = !rst_n || abort;
    h   = hold;
  endtask

  // One transfer as a timeline of phases: PRE window, per-byte fetch/wait/write/gap, POST, done.
  task automatic xfer();
    bit brk, h;
    int unsigned n;
    exp_busy = 1; exp_dl = 1; exp_index = m_idx;
    n = 0;
    while (n < PRE) begin
      tick(brk, h); if (brk) begin go_idle(); return; end
      if (!h) n++;
    end
    for (int unsigned off = 0; off < m_len; off++) begin
      exp_rd = 1; exp_saddr = AW'(off);
      tick(brk, h); exp_rd = 0; if (brk) begin go_idle(); return; end
      for (int i = 0; i < RD_LAT; i++) begin
        tick(brk, h); if (brk) begin go_idle(); return; end
      end
      exp_wr = 1; exp_addr = m_base + AW'(off); exp_dout = mem[off[7:0]];
      tick(brk, h); exp_wr = 0; if (brk) begin go_idle(); return; end
      if (off + 1 < m_len) begin
        n = 0;
        while (n < GAP) begin
          tick(brk, h); if (brk) begin go_idle(); return; end
          if (!h) n++;
        end
      end
    end
    repeat (POST) begin
      tick(brk, h); if (brk) begin go_idle(); return; end
    end
    exp_dl = 0; exp_done = 1;
    tick(brk, h);
    exp_done = 0; exp_busy = 0;
    if (brk) go_idle();
  endtask

  initial begin
    zero_all();
    forever begin
      @(posedge clk_sys or negedge rst_n);
      if (!rst_n) zero_all();
      else if (start && !abort) begin
        m_idx = index_in; m_base = dst_base; m_len = length;
        xfer();
      end
    end
  end

  // Per-cycle compare plus event log used by the directed scenarios.
  int wr_n = 0, done_n = 0, dl_n = 0, rd_n = 0;
  int wr_cyc [LOG];
  logic [AW-1:0] wr_addr [LOG];
  logic [7:0] wr_dat [LOG];
  int done_cyc [LOG];

  initial forever begin
    @(negedge clk_sys);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("ioctl_download", 32'(ioctl_download), 32'(exp_dl));
    chk("ioctl_wr", 32'(ioctl_wr), 32'(exp_wr));
    chk("src_rd", 32'(src_rd), 32'(exp_rd));
    chk("done", 32'(done), 32'(exp_done));
    chk("src_addr", 32'(src_addr), 32'(exp_saddr));
    chk("ioctl_addr", 32'(ioctl_addr), 32'(exp_addr));
    chk("ioctl_dout", 32'(ioctl_dout), 32'(exp_dout));
    chk("ioctl_index", 32'(ioctl_index), 32'(exp_index));
    if (ioctl_wr && wr_n < LOG) begin
      wr_cyc[wr_n] = cyc; wr_addr[wr_n] = ioctl_addr; wr_dat[wr_n] = ioctl_dout; wr_n++;
    end
    if (done && done_n < LOG) begin done_cyc[done_n] = cyc; done_n++; end
    if (ioctl_download) dl_n++;
    if (src_rd) rd_n++;
  end

  task automatic do_start(input logic [7:0] idx, input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(negedge clk_sys);
    index_in = idx; dst_base = b; length = l; start = 1;
    @(negedge clk_sys);
    start = 0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 2000) begin @(negedge clk_sys); k++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_dl"}, 32'(ioctl_download), 32'd0);
    chk({tag, "_wr"}, 32'(ioctl_wr), 32'd0);
    chk({tag, "_rd"}, 32'(src_rd), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_saddr"}, 32'(src_addr), 32'd0);
    chk({tag, "_addr"}, 32'(ioctl_addr), 32'd0);
    chk({tag, "_dout"}, 32'(ioctl_dout), 32'd0);
    chk({tag, "_index"}, 32'(ioctl_index), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, l0, r0, n, k;
    logic [AW-1:0] top;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
    #1 rst_n = 0;
    repeat (3) @(negedge clk_sys);
    chk_outputs_zero("reset");
    rst_n = 1;

    // 1: four bytes to 0xE000
    w0 = wr_n; d0 = done_n;
    do_start(8'h03, AW'(32'hE000), AW'(4));
    wait_idle("t1_idle");
    chk("t1_nwr", 32'(wr_n - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 32'(wr_addr[w0+i]), 32'hE000 + 32'(i));
      chk("t1_data", 32'(wr_dat[w0+i]), 32'hA0 + 32'(i));
      if (i > 0) chk("t1_period", 32'(wr_cyc[w0+i] - wr_cyc[w0+i-1]), 32'd8);
    end
    chk("t1_ndone", 32'(done_n - d0), 32'd1);
    chk("t1_done_lat", 32'(done_cyc[d0] - wr_cyc[w0+3]), 32'(POST + 1));

    // 2: zero length
    w0 = wr_n; d0 = done_n; l0 = dl_n; r0 = rd_n;
    do_start(8'hFE, AW'(32'h100), AW'(0));
    wait_idle("t2_idle");
    chk("t2_dl_cycles", 32'(dl_n - l0), 32'(PRE + POST));
    chk("t2_nwr", 32'(wr_n - w0), 32'd0);
    chk("t2_nrd", 32'(rd_n - r0), 32'd0);
    chk("t2_ndone", 32'(done_n - d0), 32'd1);

    // 3: hold for 5 cycles in the first gap
    w0 = wr_n;
    do_start(8'h01, AW'(32'h40), AW'(3));
    k = 0;
    while (!ioctl_wr && k < 200) begin @(negedge clk_sys); k++; end
    @(negedge clk_sys); hold = 1;
    repeat (5) @(negedge clk_sys);
    hold = 0;
    wait_idle("t3_idle");
    chk("t3_nwr", 32'(wr_n - w0), 32'd3);
    chk("t3_period1", 32'(wr_cyc[w0+1] - wr_cyc[w0]), 32'd13);
    chk("t3_period2", 32'(wr_cyc[w0+2] - wr_cyc[w0+1]), 32'd8);
    chk("t3_data1", 32'(wr_dat[w0+1]), 32'(mem[1]));

    // 4: reset during the read wait of byte 2
    do_start(8'h07, AW'(32'h2000), AW'(4));
    n = 0; k = 0;
    while (n < 2 && k < 200) begin @(negedge clk_sys); if (src_rd) n++; k++; end
    chk("t4_second_fetch", 32'(n), 32'd2);
    @(posedge clk_sys); #2 rst_n = 0;
    #1 chk_outputs_zero("t4_async");
    repeat (2) @(negedge clk_sys);
    rst_n = 1;
    w0 = wr_n; r0 = rd_n;
    repeat (20) @(negedge clk_sys);
    chk("t4_nwr", 32'(wr_n - w0), 32'd0);
    chk("t4_nrd", 32'(rd_n - r0), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // 5: start while busy is ignored, abort on byte 1
    w0 = wr_n; d0 = done_n;
    do_start(8'h11, AW'(32'h100), AW'(4));
    repeat (2) @(negedge clk_sys);
    do_start(8'h22, AW'(32'h200), AW'(2));
    k = 0;
    while (!src_rd && k < 200) begin @(negedge clk_sys); k++; end
    abort = 1;
    @(negedge clk_sys);
    abort = 0;
    chk("t5_dl_after_abort", 32'(ioctl_download), 32'd0);
    chk("t5_busy_after_abort", 32'(busy), 32'd0);
    repeat (20) @(negedge clk_sys);
    chk("t5_ndone", 32'(done_n - d0), 32'd0);
    chk("t5_nwr", 32'(wr_n - w0), 32'd0);
    chk("t5_index", 32'(ioctl_index), 32'h11);

    // 6: address wrap at the top of the AW space
    w0 = wr_n;
    top = '1;
    do_start(8'h02, top - AW'(1), AW'(4));
    wait_idle("t6_idle");
    chk("t6_nwr", 32'(wr_n - w0), 32'd4);
    chk("t6_addr0", 32'(wr_addr[w0]), 32'h1FF_FFFE);
    chk("t6_addr1", 32'(wr_addr[w0+1]), 32'h1FF_FFFF);
    chk("t6_addr2", 32'(wr_addr[w0+2]), 32'h0);
    chk("t6_addr3", 32'(wr_addr[w0+3]), 32'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys);
      start    = ($urandom_range(0, 11) == 0);
      abort    = ($urandom_range(0, 199) == 0);
      hold     = ($urandom_range(0, 3) == 0);
      index_in = 8'($urandom);
      dst_base = ($urandom_range(0, 3) == 0) ? ~AW'($urandom_range(0, 3)) : AW'($urandom);
      length   = AW'($urandom_range(0, 6));
    end
    @(negedge clk_sys);
    start = 0; abort = 0; hold = 0;
    wait_idle("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
